sme_host: RTL and testbench
===========================

SME_HOST -- requirements
Module: sme_host

Interface
REQ-001 The block SHALL expose the parameter STR_MAX, default 32, meaning the string buffer depth in characters.
REQ-002 The block SHALL expose the parameter PAT_MAX, default 8, meaning the pattern buffer depth in characters.
REQ-003 The block SHALL expose the parameter TIMEOUT_CYC, default 1000, meaning the maximum number of cycles spent waiting for out_valid.
REQ-004 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high. The ports SHALL be as listed below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 ld_en  in  1  buffer write strobe.
REQ-008 ld_sel  in  1  buffer select: 0 = string buffer, 1 = pattern buffer.
REQ-009 ld_addr  in  5  character slot to write.
REQ-010 ld_data  in  8  character to write.
REQ-011 start  in  1  single-cycle command pulse.
REQ-012 send_str  in  1  when 1, send the string before the pattern.
REQ-013 str_len  in  6  string length, legal range 1..32.
REQ-014 pat_len  in  4  pattern length, legal range 1..8.
REQ-015 busy  out  1  high from command acceptance through the result pulse.
REQ-016 chardata  out  8  character driven to the matcher.
REQ-017 isstring  out  1  qualifies chardata as a string character.
REQ-018 ispattern  out  1  qualifies chardata as a pattern character.
REQ-019 out_valid  in  1  result strobe from the matcher.
REQ-020 match  in  1  match flag from the matcher.
REQ-021 match_index  in  5  match position from the matcher.
REQ-022 res_valid  out  1  one-cycle result pulse.
REQ-023 res_match, res_index, res_timeout  out  1 / 5 / 1  captured result fields.

Function
REQ-024 Buffer writes (ld_en=1) SHALL take effect at the clock edge.
- Writes SHALL be ignored while busy=1.
- Writes with ld_sel=1 and ld_addr>=PAT_MAX SHALL be ignored.
REQ-025 The FSM SHALL have the states IDLE, SEND_STR, GAP, SEND_PAT, WAIT and REPORT.
REQ-026 In IDLE, start=1 with pat_len in the range 1..8 SHALL be accepted; otherwise start SHALL be ignored.
- On acceptance, the lengths SHALL be latched and busy SHALL rise on the next cycle.
- The next state SHALL be SEND_STR if send_str=1 and str_len is nonzero, else SEND_PAT.
- str_len above 32 SHALL clamp to 32.
REQ-027 start SHALL be ignored in every state other than IDLE.
REQ-028 SEND_STR SHALL drive isstring=1 for exactly str_len consecutive cycles, with chardata equal to string[0..str_len-1] in order, then go to GAP.
REQ-029 GAP SHALL last exactly one cycle with isstring=0 and ispattern=0, then go to SEND_PAT.
REQ-030 SEND_PAT SHALL drive ispattern=1 for exactly pat_len consecutive cycles, with chardata equal to pattern[0..pat_len-1], then go to WAIT.
REQ-031 chardata, isstring and ispattern SHALL be registered outputs; chardata SHALL be 0 whenever both strobes are low.
REQ-032 isstring and ispattern SHALL never be high in the same cycle.
REQ-033 out_valid SHALL be ignored outside WAIT.
REQ-034 In WAIT, the first cycle with out_valid=1 SHALL capture match and match_index into res_match and res_index, set res_timeout=0, and go to REPORT.
REQ-035 The WAIT cycle counter SHALL start at 0 on entry. If it reaches TIMEOUT_CYC-1 with no out_valid, the block SHALL go to REPORT with res_timeout=1, res_match=0 and res_index=0.
REQ-036 REPORT SHALL assert res_valid for exactly one cycle, then return to IDLE.
- busy SHALL be low in the cycle after REPORT.
- res_match, res_index and res_timeout SHALL hold their values until the next REPORT.
REQ-037 If out_valid and the timeout coincide in the same cycle, out_valid SHALL win and res_timeout SHALL be 0.

Reset
REQ-038 Asserting rst SHALL immediately force IDLE, with busy, isstring, ispattern, res_valid, res_match, res_timeout=0 and chardata, res_index=0; this SHALL hold in any state, including mid-transmission.
REQ-039 Buffer contents SHALL NOT be reset.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, STR_MAX, PAT_MAX and TIMEOUT_CYC.
REQ-041 The character buffers SHALL be a single sub-module, sme_host_buf, with two banks, one write port and one read port.

Verification
REQ-042 Load "ABCDE" as the string and "CD" as the pattern; start with send_str=1, str_len=5, pat_len=2.
- Required: isstring high for 5 cycles carrying 41..45h, then 1 gap cycle, then ispattern high for 2 cycles carrying 43h,44h.
- The model then returns out_valid with match=1 and match_index=2; required: res_valid pulse with res_match=1, res_index=2.
REQ-043 Start with send_str=0 and pat_len=3.
- Required: no isstring cycles, ispattern for 3 cycles, and the result is captured.
REQ-044 The model never asserts out_valid.
- Required: res_valid exactly TIMEOUT_CYC cycles after WAIT entry, with res_timeout=1, res_match=0 and res_index=0.
REQ-045 Pulse start while busy, write ld_en while busy, and start with pat_len=0.
- Required: no new transaction and buffers unchanged.
REQ-046 Assert rst during SEND_STR.
- Required: outputs are 0 in the same cycle and the FSM is in IDLE.
- A subsequent start replays the unchanged buffers.

Source files
------------

// File: rtl/sme_host_pkg.sv
// Shared types and default sizing for the string-matching-engine host.
package sme_host_pkg;

  localparam int unsigned STR_MAX     = 32;
  localparam int unsigned PAT_MAX     = 8;
  localparam int unsigned TIMEOUT_CYC = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StGap,
    StSendPat,
    StWait,
    StReport
  } state_e;

endpackage

// File: rtl/sme_host_buf.sv
// Character store: a string bank and a pattern bank sharing one write and one read port.
module sme_host_buf
  import sme_host_pkg::*;
#(
  parameter int unsigned StrDepth = STR_MAX,
  parameter int unsigned PatDepth = PAT_MAX
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic       sel_i,
  input  logic [4:0] addr_i,
  input  logic [7:0] data_i,
  input  logic       rd_sel_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  localparam int unsigned SW = (StrDepth > 1) ? $clog2(StrDepth) : 1;
  localparam int unsigned PW = (PatDepth > 1) ? $clog2(PatDepth) : 1;

  logic [7:0] str_mem [StrDepth];
  logic [7:0] pat_mem [PatDepth];

  // Contents are deliberately not reset so a reset can be followed by a replay.
  always_ff @(posedge clk_i) begin
    if (we_i && !sel_i && (32'(addr_i) < StrDepth)) str_mem[addr_i[SW-1:0]] <= data_i;
    if (we_i && sel_i && (32'(addr_i) < PatDepth)) pat_mem[addr_i[PW-1:0]] <= data_i;
  end

  assign rd_data_o = rd_sel_i ? pat_mem[rd_addr_i[PW-1:0]] : str_mem[rd_addr_i[SW-1:0]];

endmodule

// File: rtl/sme_host.sv
// Host sequencer: streams string then pattern to a matcher and collects its verdict.
module sme_host #(
  parameter int unsigned STR_MAX     = sme_host_pkg::STR_MAX,
  parameter int unsigned PAT_MAX     = sme_host_pkg::PAT_MAX,
  parameter int unsigned TIMEOUT_CYC = sme_host_pkg::TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_en,
  input  logic       ld_sel,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       start,
  input  logic       send_str,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       out_valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);
  import sme_host_pkg::*;

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [5:0]      str_len_q, str_len_d;
  logic [3:0]      pat_len_q, pat_len_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            res_match_q, res_match_d, res_timeout_q, res_timeout_d;
  logic [4:0]      res_index_q, res_index_d;
  logic [7:0]      chardata_q, chardata_d;
  logic            isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic [7:0]      rd_data;
  logic            accept;

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StReport);
  assign accept    = start && (pat_len != 4'd0) && (32'(pat_len) <= PAT_MAX);

  sme_host_buf #(
    .StrDepth (STR_MAX),
    .PatDepth (PAT_MAX)
  ) u_buf (
    .clk_i     (clk),
    .we_i      (ld_en && !busy),
    .sel_i     (ld_sel),
    .addr_i    (ld_addr),
    .data_i    (ld_data),
    .rd_sel_i  (state_d == StSendPat),
    .rd_addr_i (idx_d[4:0]),
    .rd_data_o (rd_data)
  );

  // Next-state, slot index, wait counter and result capture.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    cnt_d         = cnt_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          str_len_d = (32'(str_len) > STR_MAX) ? 6'(STR_MAX) : str_len;
          pat_len_d = pat_len;
          idx_d     = '0;
          state_d   = (send_str && (str_len != 6'd0)) ? StSendStr : StSendPat;
        end
      end
      StSendStr: begin
        if (idx_q == str_len_q - 6'd1) begin
          idx_d   = '0;
          state_d = StGap;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StGap: begin
        idx_d   = '0;
        state_d = StSendPat;
      end
      StSendPat: begin
        if (idx_q == {2'b00, pat_len_q} - 6'd1) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StWait: begin
        // out_valid has priority over a timeout landing in the same cycle.
        if (out_valid) begin
          res_match_d   = match;
          res_index_d   = match_index;
          res_timeout_d = 1'b0;
          state_d       = StReport;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
          state_d       = StReport;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output strobes are registered from the next state so they line up with the state.
  always_comb begin
    isstring_d  = (state_d == StSendStr);
    ispattern_d = (state_d == StSendPat);
    chardata_d  = (isstring_d || ispattern_d) ? rd_data : 8'h00;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      cnt_q         <= '0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      cnt_q         <= cnt_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
    end
  end

  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_sme_host.sv
// Directed bench for sme_host with a simple scripted matcher.
module tb_sme_host;

  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_en = 1'b0, ld_sel = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       start = 1'b0, send_str = 1'b0;
  logic [5:0] str_len = '0;
  logic [3:0] pat_len = '0;
  logic       busy, isstring, ispattern, res_valid, res_match, res_timeout;
  logic [7:0] chardata;
  logic       out_valid = 1'b0, match = 1'b0;
  logic [4:0] match_index = '0;
  logic [4:0] res_index;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] str_q[$];
  logic [7:0] pat_q[$];
  int         gap_cnt, both_cnt, zero_err, rv_at, done;
  logic       busy_first, first_pat, r_match, r_timeout;
  logic [4:0] r_index;

  sme_host dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_sel      (ld_sel),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .start       (start),
    .send_str    (send_str),
    .str_len     (str_len),
    .pat_len     (pat_len),
    .busy        (busy),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .out_valid   (out_valid),
    .match       (match),
    .match_index (match_index),
    .res_valid   (res_valid),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_timeout (res_timeout)
  );

  always #5 clk = ~clk;

  task automatic load_buf(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts one command and records the streamed characters and the result.
  task automatic run_txn(input bit ss, input logic [5:0] sl, input logic [3:0] pl,
                         input bit respond, input int delay, input logic m,
                         input logic [4:0] mi, input bit noise, input bit disturb);
    bit prev_pat, in_wait;
    int wait_cnt;
    str_q.delete(); pat_q.delete();
    gap_cnt = 0; both_cnt = 0; zero_err = 0; rv_at = -1; done = 0;
    prev_pat = 0; in_wait = 0; wait_cnt = 0;
    @(negedge clk);
    send_str = ss; str_len = sl; pat_len = pl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_first = busy;
    first_pat  = ispattern;
    for (int cyc = 0; cyc < T + 100 && done == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (disturb) begin
        start   = (cyc == 1);
        ld_en   = (cyc == 1 || cyc == 2);
        ld_sel  = (cyc == 1);
        ld_addr = 5'd0;
        ld_data = 8'h5A;
      end
      if (in_wait) wait_cnt++;
      if (prev_pat && !ispattern) begin in_wait = 1; wait_cnt = 0; end
      if (isstring) str_q.push_back(chardata);
      if (ispattern) pat_q.push_back(chardata);
      if (isstring && ispattern) both_cnt++;
      if (!isstring && !ispattern && chardata !== 8'h00) zero_err++;
      if (str_q.size() > 0 && pat_q.size() == 0 && !isstring && !ispattern) gap_cnt++;
      out_valid = noise && !in_wait;
      match = ~m; match_index = ~mi;
      if (respond && in_wait && wait_cnt == delay) begin
        out_valid = 1'b1; match = m; match_index = mi;
      end
      if (res_valid) begin
        rv_at = in_wait ? wait_cnt : -1;
        r_match = res_match; r_index = res_index; r_timeout = res_timeout;
        done = 1; out_valid = 1'b0;
      end
      prev_pat = ispattern;
    end
    out_valid = 1'b0; start = 1'b0; ld_en = 1'b0;
    n_checks++;
    if (done == 0) begin
      n_fail++; $display("FAIL txn_done: res_valid not seen, got none want pulse");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, isstring, ispattern, res_valid, res_match, res_timeout, chardata, res_index} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b is=%b ip=%b rv=%b rm=%b rt=%b cd=%h ri=%0d want all 0",
               busy, isstring, ispattern, res_valid, res_match, res_timeout, chardata, res_index);
    end
    rst = 1'b0;
  endtask

  task automatic test_match();
    for (int i = 0; i < 5; i++) load_buf(1'b0, 5'(i), 8'(65 + i));
    load_buf(1'b1, 5'd0, 8'h43);
    load_buf(1'b1, 5'd1, 8'h44);
    run_txn(1, 6'd5, 4'd2, 1, 3, 1'b1, 5'd2, 0, 0);
    n_checks++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", busy_first); end
    n_checks++; if (str_q.size() != 5) begin n_fail++; $display("FAIL str_len: got %0d want 5", str_q.size()); end
    for (int i = 0; i < 5 && i < str_q.size(); i++) begin
      n_checks++;
      if (str_q[i] !== 8'(65 + i)) begin n_fail++; $display("FAIL str_char%0d: got %h want %h", i, str_q[i], 8'(65 + i)); end
    end
    n_checks++; if (gap_cnt != 1) begin n_fail++; $display("FAIL gap: got %0d want 1", gap_cnt); end
    n_checks++; if (pat_q.size() != 2) begin n_fail++; $display("FAIL pat_len: got %0d want 2", pat_q.size()); end
    for (int i = 0; i < 2 && i < pat_q.size(); i++) begin
      n_checks++;
      if (pat_q[i] !== 8'(67 + i)) begin n_fail++; $display("FAIL pat_char%0d: got %h want %h", i, pat_q[i], 8'(67 + i)); end
    end
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL strobe_excl: got %0d want 0", both_cnt); end
    n_checks++; if (zero_err != 0) begin n_fail++; $display("FAIL idle_char: got %0d want 0", zero_err); end
    n_checks++; if (rv_at != 4) begin n_fail++; $display("FAIL match_lat: got %0d want 4", rv_at); end
    n_checks++;
    if ({r_match, r_index, r_timeout} !== {1'b1, 5'd2, 1'b0}) begin
      n_fail++; $display("FAIL match_res: got m=%b i=%0d t=%b want m=1 i=2 t=0", r_match, r_index, r_timeout);
    end
    @(negedge clk);
    n_checks++;
    if ({res_valid, busy, res_match, res_index} !== {1'b0, 1'b0, 1'b1, 5'd2}) begin
      n_fail++; $display("FAIL after_report: got rv=%b busy=%b m=%b i=%0d want 0 0 1 2",
                         res_valid, busy, res_match, res_index);
    end
  endtask

  task automatic test_timeout();
    run_txn(1, 6'd0, 4'd2, 0, 0, 1'b0, 5'd0, 0, 0);
    n_checks++; if (str_q.size() != 0 || first_pat !== 1'b1) begin n_fail++; $display("FAIL zero_str: got %0d/%b want 0/1", str_q.size(), first_pat); end
    n_checks++; if (rv_at != T) begin n_fail++; $display("FAIL timeout_lat: got %0d want %0d", rv_at, T); end
    n_checks++;
    if ({r_match, r_index, r_timeout} !== {1'b0, 5'd0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_res: got m=%b i=%0d t=%b want m=0 i=0 t=1", r_match, r_index, r_timeout);
    end
  endtask

  task automatic test_no_string();
    load_buf(1'b1, 5'd2, 8'h58);
    run_txn(0, 6'd5, 4'd3, 1, 0, 1'b0, 5'd7, 1, 0);
    n_checks++; if (str_q.size() != 0 || first_pat !== 1'b1) begin n_fail++; $display("FAIL nostr: got %0d/%b want 0/1", str_q.size(), first_pat); end
    n_checks++;
    if (pat_q.size() != 3 || pat_q[0] !== 8'h43 || pat_q[1] !== 8'h44 || pat_q[2] !== 8'h58) begin
      n_fail++; $display("FAIL nostr_pat: got %0d chars want 43 44 58", pat_q.size());
    end
    n_checks++; if (rv_at != 1) begin n_fail++; $display("FAIL nostr_lat: got %0d want 1", rv_at); end
    n_checks++;
    if ({r_match, r_index, r_timeout} !== {1'b0, 5'd7, 1'b0}) begin
      n_fail++; $display("FAIL nostr_res: got m=%b i=%0d t=%b want m=0 i=7 t=0", r_match, r_index, r_timeout);
    end
  endtask

  task automatic test_coincide();
    run_txn(1, 6'd40, 4'd1, 1, T - 1, 1'b1, 5'd17, 0, 0);
    n_checks++; if (str_q.size() != 32) begin n_fail++; $display("FAIL clamp: got %0d want 32", str_q.size()); end
    n_checks++; if (pat_q.size() != 1) begin n_fail++; $display("FAIL pat1: got %0d want 1", pat_q.size()); end
    n_checks++; if (rv_at != T) begin n_fail++; $display("FAIL coin_lat: got %0d want %0d", rv_at, T); end
    n_checks++;
    if ({r_match, r_index, r_timeout} !== {1'b1, 5'd17, 1'b0}) begin
      n_fail++; $display("FAIL coin_res: got m=%b i=%0d t=%b want m=1 i=17 t=0", r_match, r_index, r_timeout);
    end
  endtask

  task automatic test_ignore();
    int busy_hi;
    run_txn(1, 6'd5, 4'd2, 1, 2, 1'b1, 5'd3, 0, 1);
    n_checks++; if (str_q.size() != 5) begin n_fail++; $display("FAIL busy_start: got %0d want 5", str_q.size()); end
    n_checks++; if (rv_at != 3 || r_index !== 5'd3) begin n_fail++; $display("FAIL busy_res: got %0d/%0d want 3/3", rv_at, r_index); end
    busy_hi = 0;
    repeat (5) begin @(negedge clk); if (busy) busy_hi++; end
    @(negedge clk); pat_len = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) begin if (busy || isstring || ispattern) busy_hi++; @(negedge clk); end
    n_checks++; if (busy_hi != 0) begin n_fail++; $display("FAIL no_new_txn: got %0d busy cycles want 0", busy_hi); end
    load_buf(1'b1, 5'd8, 8'h5A);
    run_txn(1, 6'd5, 4'd2, 1, 0, 1'b1, 5'd1, 0, 0);
    n_checks++;
    if (str_q.size() != 5 || str_q[0] !== 8'h41 || str_q[4] !== 8'h45) begin
      n_fail++; $display("FAIL str_kept: got %0d chars first %h want 5 first 41", str_q.size(), str_q[0]);
    end
    n_checks++;
    if (pat_q.size() != 2 || pat_q[0] !== 8'h43 || pat_q[1] !== 8'h44) begin
      n_fail++; $display("FAIL pat_kept: got %0d chars first %h want 2 first 43", pat_q.size(), pat_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); send_str = 1'b1; str_len = 6'd5; pat_len = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_checks++; if (isstring !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", isstring); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, isstring, ispattern, res_valid, res_match, res_timeout, chardata, res_index} !== '0)
    begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b is=%b ip=%b rv=%b rm=%b rt=%b cd=%h ri=%0d want all 0",
               busy, isstring, ispattern, res_valid, res_match, res_timeout, chardata, res_index);
    end
    @(negedge clk); rst = 1'b0;
    run_txn(1, 6'd5, 4'd2, 1, 0, 1'b0, 5'd9, 0, 0);
    n_checks++;
    if (str_q.size() != 5 || str_q[1] !== 8'h42 || str_q[3] !== 8'h44) begin
      n_fail++; $display("FAIL replay_str: got %0d chars want ABCDE", str_q.size());
    end
    n_checks++;
    if (pat_q.size() != 2 || r_index !== 5'd9) begin
      n_fail++; $display("FAIL replay_res: got %0d pat idx %0d want 2 idx 9", pat_q.size(), r_index);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_timeout();
    test_no_string();
    test_coincide();
    test_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
